uart_rx_ctrl: RTL

UART receiver, the companion to the team's UART transmit controller: 8N1, LSB first, idle-high line. It takes the asynchronous serial input, synchronises it, and validates the start bit at mid-bit. It then samples 8 data bits and checks the stop bit, presenting each received byte with a one-cycle valid strobe. It feeds the command/config path that the host drives over the same serial link.

---
 rtl/uart_rx_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver, LSB first, idle-high line.
//
// The async line is synchronised through two flops. A falling edge is confirmed
// low at mid-start-bit, then 8 data bits are sampled one bit period apart,
// followed by the stop bit. A good frame updates DATA and pulses DATA_VALID for
// one cycle. A low stop bit pulses FRAME_ERR and leaves DATA unchanged. The
// receiver then waits for the line to go high again before looking for the
// next start bit.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   UART_RX     asynchronous serial input, idle high
//   DATA        last correctly framed byte
//   DATA_VALID  one-cycle pulse when DATA updates
//   FRAME_ERR   one-cycle pulse when the stop bit is sampled low
//   BUSY        registered, high while the receiver is not idle
module uart_rx_ctrl #(
  parameter int unsigned BIT_TMR_MAX = 10415,
  parameter int unsigned HALF_TMR    = BIT_TMR_MAX / 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [13:0] TmrMax  = 14'(BIT_TMR_MAX);
  localparam logic [13:0] TmrHalf = 14'(HALF_TMR);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e      state;
  logic        rxMeta;
  logic        rxLine;
  logic [13:0] timer;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= StIdle;
      rxMeta     <= 1'b1;
      rxLine     <= 1'b1;
      timer      <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      rxMeta     <= UART_RX;
      rxLine     <= rxMeta;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      // Lags the state register by one cycle.
      BUSY       <= (state != StIdle);

      unique case (state)
        StIdle: begin
          timer <= '0;
          if (!rxLine) begin
            state <= StStart;
          end
        end

        StStart: begin
          if (timer == TmrHalf) begin
            timer <= '0;
            if (!rxLine) begin
              state  <= StData;
              bitIdx <= '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state <= StIdle;
            end
          end else begin
            timer <= timer + 14'd1;
          end
        end

        StData: begin
          if (timer == TmrMax) begin
            timer            <= '0;
            shiftReg[bitIdx] <= rxLine;
            bitIdx           <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) begin
              state <= StStop;
            end
          end else begin
            timer <= timer + 14'd1;
          end
        end

        StStop: begin
          if (timer == TmrMax) begin
            timer <= '0;
            if (rxLine) begin
              DATA       <= shiftReg;
              DATA_VALID <= 1'b1;
              // Leaving at mid-stop-bit lets a back-to-back start bit be seen.
              state      <= StIdle;
            end else begin
              FRAME_ERR <= 1'b1;
              state     <= StWaitHigh;
            end
          end else begin
            timer <= timer + 14'd1;
          end
        end

        StWaitHigh: begin
          // A break or stuck-low line must not retrigger frames.
          timer <= '0;
          if (rxLine) begin
            state <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
